// File: rtl/config_reg.sv
// ---------------------------------------------------------------------------
// config_reg
// Memory-mapped configuration/status register bank for an accelerator.
//
// Address map (word addresses):
//   0 .. N_CTRL_WORDS-1                          control words, read/write
//   N_CTRL_WORDS .. N_CTRL_WORDS+N_STAT_WORDS-1  status words, read-only
//   anything above                                unmapped (reads 0)
//
// Ports:
//   clk_s     clock, all state on the rising edge
//   rst_n_s   asynchronous active-low reset
//   ctrl_vec  control word registers driven to the datapath
//   stat_vec  status words from the datapath
//   stat_en   capture enable for the status shadows (REGISTER_STATUS=1)
//   en        bus access strobe
//   addr      word address
//   we        1 = write, 0 = read (qualified by en)
//   be        byte enables for writes
//   wdata     write data
//   rdata     read data (combinational when ASYNC_READ=1, else 1-cycle latency)
// ---------------------------------------------------------------------------
module config_reg #(
    parameter int ASYNC_READ      = 1,
    parameter int N_CTRL_WORDS    = 2,
    parameter int N_STAT_WORDS    = 4,
    parameter int ADDR_WIDTH      = $clog2(N_CTRL_WORDS + N_STAT_WORDS),
    parameter int DATA_WIDTH      = 32,
    parameter int REGISTER_STATUS = 0
) (
    input  logic                    clk_s,
    input  logic                    rst_n_s,
    output logic [DATA_WIDTH-1:0]   ctrl_vec [N_CTRL_WORDS],
    input  logic [DATA_WIDTH-1:0]   stat_vec [N_STAT_WORDS],
    input  logic                    stat_en,
    input  logic                    en,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic                    we,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH-1:0]   rdata
);

    localparam int N_BYTES = DATA_WIDTH / 8;

    logic                  wr_en;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] ctrl_reg  [N_CTRL_WORDS];
    logic [DATA_WIDTH-1:0] ctrl_next [N_CTRL_WORDS];
    logic [DATA_WIDTH-1:0] stat_reg  [N_STAT_WORDS];
    logic [DATA_WIDTH-1:0] stat_src  [N_STAT_WORDS];
    logic [DATA_WIDTH-1:0] rd_sel;
    logic [DATA_WIDTH-1:0] rdata_reg;

    assign wr_en = en & we;
    assign rd_en = en & ~we;

    // -----------------------------------------------------------------------
    // Control words: byte-granular write merge, one register per word.
    // Writes whose address is outside the control range match no word and
    // therefore have no effect.
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < N_CTRL_WORDS; gi++) begin : g_ctrl
            always_comb begin
                ctrl_next[gi] = ctrl_reg[gi];
                if (wr_en && (addr == ADDR_WIDTH'(gi))) begin
                    for (int bi = 0; bi < N_BYTES; bi++) begin
                        if (be[bi]) begin
                            ctrl_next[gi][8*bi +: 8] = wdata[8*bi +: 8];
                        end
                    end
                end
            end

            always_ff @(posedge clk_s or negedge rst_n_s) begin
                if (!rst_n_s) begin
                    ctrl_reg[gi] <= '0;
                end else begin
                    ctrl_reg[gi] <= ctrl_next[gi];
                end
            end

            assign ctrl_vec[gi] = ctrl_reg[gi];
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Status source. Both the shadow and the direct path are described; the
    // parameter picks one and the other is trimmed away by synthesis.
    // -----------------------------------------------------------------------
    generate
        for (gi = 0; gi < N_STAT_WORDS; gi++) begin : g_stat
            always_ff @(posedge clk_s or negedge rst_n_s) begin
                if (!rst_n_s) begin
                    stat_reg[gi] <= '0;
                end else if (stat_en) begin
                    stat_reg[gi] <= stat_vec[gi];
                end
            end

            assign stat_src[gi] = (REGISTER_STATUS != 0) ? stat_reg[gi] : stat_vec[gi];
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Read select: control word, status word, or 0 for unmapped addresses.
    // -----------------------------------------------------------------------
    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < N_CTRL_WORDS; i++) begin
            if (addr == ADDR_WIDTH'(i)) begin
                rd_sel = ctrl_reg[i];
            end
        end
        for (int i = 0; i < N_STAT_WORDS; i++) begin
            if (addr == ADDR_WIDTH'(N_CTRL_WORDS + i)) begin
                rd_sel = stat_src[i];
            end
        end
    end

    // Registered read data holds its value between reads.
    always_ff @(posedge clk_s or negedge rst_n_s) begin
        if (!rst_n_s) begin
            rdata_reg <= '0;
        end else if (rd_en) begin
            rdata_reg <= rd_sel;
        end
    end

    assign rdata = (ASYNC_READ != 0) ? (rd_en ? rd_sel : '0) : rdata_reg;

endmodule

// File: tb/tb_config_reg.sv
// ---------------------------------------------------------------------------
// tb_config_reg
// Two instances share clock, reset and bus: dut_a (ASYNC_READ=1,
// REGISTER_STATUS=0) and dut_s (ASYNC_READ=0, REGISTER_STATUS=1).
// Stimulus pushes expected values tagged with the cycle they are due; a
// monitor on the falling edge pops and compares them.
// ---------------------------------------------------------------------------
module tb_config_reg;

    localparam int DW = 16;
    localparam int AW = 3;

    logic          clk_s = 1'b0;
    logic          rst_n_s;
    logic          en, we, stat_en;
    logic [AW-1:0] addr;
    logic [1:0]    be;
    logic [DW-1:0] wdata;
    logic [DW-1:0] ctrl_a [2];
    logic [DW-1:0] ctrl_s [2];
    logic [DW-1:0] stat_a [4];
    logic [DW-1:0] stat_s [4];
    logic [DW-1:0] rdata_a, rdata_s;

    config_reg #(.ASYNC_READ(1), .N_CTRL_WORDS(2), .N_STAT_WORDS(4), .ADDR_WIDTH(AW),
                 .DATA_WIDTH(DW), .REGISTER_STATUS(0)) dut_a (
        .clk_s(clk_s), .rst_n_s(rst_n_s), .ctrl_vec(ctrl_a), .stat_vec(stat_a),
        .stat_en(stat_en), .en(en), .addr(addr), .we(we), .be(be),
        .wdata(wdata), .rdata(rdata_a));

    config_reg #(.ASYNC_READ(0), .N_CTRL_WORDS(2), .N_STAT_WORDS(4), .ADDR_WIDTH(AW),
                 .DATA_WIDTH(DW), .REGISTER_STATUS(1)) dut_s (
        .clk_s(clk_s), .rst_n_s(rst_n_s), .ctrl_vec(ctrl_s), .stat_vec(stat_s),
        .stat_en(stat_en), .en(en), .addr(addr), .we(we), .be(be),
        .wdata(wdata), .rdata(rdata_s));

    always #5 clk_s = ~clk_s;

    int cyc = 0;
    always @(posedge clk_s) cyc <= cyc + 1;

    // Probe selectors
    localparam int RD_A = 0, C0_A = 1, C1_A = 2, RD_S = 3, C0_S = 4;

    typedef struct {
        int            due;
        int            sel;
        logic [DW-1:0] exp;
        string         name;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic expect_at(input int due, input int sel, input logic [DW-1:0] v,
                             input string nm);
        exp_t e;
        e.due = due; e.sel = sel; e.exp = v; e.name = nm;
        sb.push_back(e);
    endtask

    function automatic logic [DW-1:0] probe(input int sel);
        case (sel)
            RD_A:    return rdata_a;
            C0_A:    return ctrl_a[0];
            C1_A:    return ctrl_a[1];
            RD_S:    return rdata_s;
            C0_S:    return ctrl_s[0];
            default: return 'x;
        endcase
    endfunction

    // Monitor: compare everything due this cycle; anything overdue is a miss.
    always @(negedge clk_s) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                logic [DW-1:0] act;
                act = probe(sb[i].sel);
                total++;
                if (act !== sb[i].exp) begin
                    bad++;
                    $display("FAIL %s cyc=%0d got=%h exp=%h", sb[i].name, cyc, act, sb[i].exp);
                end else begin
                    $display("ok   %s cyc=%0d val=%h", sb[i].name, cyc, act);
                end
                sb.delete(i);
            end else if (sb[i].due < cyc) begin
                total++;
                bad++;
                $display("FAIL %s never checked due=%0d now=%0d", sb[i].name, sb[i].due, cyc);
                sb.delete(i);
            end
        end
    end

    // One bus cycle: inputs change just after the rising edge.
    task automatic step(input logic e, input logic w, input logic [AW-1:0] a,
                        input logic [1:0] b, input logic [DW-1:0] d);
        @(posedge clk_s);
        #1;
        en = e; we = w; addr = a; be = b; wdata = d;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, '0, 2'b00, '0);
    endtask

    initial begin
        rst_n_s = 1'b0; en = 1'b0; we = 1'b0; stat_en = 1'b0;
        addr = '0; be = '0; wdata = '0;
        for (int i = 0; i < 4; i++) begin
            stat_a[i] = DW'(i);
            stat_s[i] = DW'(i);
        end

        // Reset / idle
        repeat (2) @(posedge clk_s);
        #1;
        rst_n_s = 1'b1;
        expect_at(cyc, C0_A, 16'h0000, "reset_ctrl0");
        expect_at(cyc, C1_A, 16'h0000, "reset_ctrl1");
        expect_at(cyc, RD_A, 16'h0000, "reset_rdata_a");
        expect_at(cyc, RD_S, 16'h0000, "reset_rdata_s");

        // Full writes
        step(1, 1, 3'd0, 2'b11, 16'h0100);
        step(1, 1, 3'd1, 2'b11, 16'h0302);
        expect_at(cyc, C0_A, 16'h0100, "wr_ctrl0");
        idle();
        expect_at(cyc, C1_A, 16'h0302, "wr_ctrl1");

        // Status and control reads, combinational
        for (int i = 0; i < 4; i++) begin
            step(1, 0, AW'(2 + i), 2'b00, 16'h0000);
            expect_at(cyc, RD_A, DW'(i), $sformatf("rd_stat%0d", i));
        end
        step(1, 0, 3'd0, 2'b00, 16'h0000);
        expect_at(cyc, RD_A, 16'h0100, "rd_ctrl0");
        step(1, 0, 3'd1, 2'b00, 16'h0000);
        expect_at(cyc, RD_A, 16'h0302, "rd_ctrl1");

        // Byte enables, read-after-write
        step(1, 1, 3'd0, 2'b01, 16'hAAFF);
        expect_at(cyc, RD_A, 16'h0000, "rdata_zero_on_write");
        step(1, 0, 3'd0, 2'b00, 16'h0000);
        expect_at(cyc, RD_A, 16'h01FF, "be_low");
        step(1, 1, 3'd0, 2'b10, 16'h55AA);
        step(1, 0, 3'd0, 2'b00, 16'h0000);
        expect_at(cyc, RD_A, 16'h55FF, "be_high");

        // Ignored writes
        step(1, 1, 3'd3, 2'b11, 16'hFFFF);
        step(1, 0, 3'd3, 2'b00, 16'h0000);
        expect_at(cyc, RD_A, 16'h0001, "stat_wr_ignored");
        expect_at(cyc, C0_A, 16'h55FF, "stat_wr_ctrl0");
        expect_at(cyc, C1_A, 16'h0302, "stat_wr_ctrl1");
        step(1, 0, 3'd7, 2'b00, 16'h0000);
        expect_at(cyc, RD_A, 16'h0000, "rd_unmapped");
        step(1, 1, 3'd7, 2'b11, 16'hFFFF);
        step(1, 1, 3'd0, 2'b00, 16'h1234);
        expect_at(cyc, C0_A, 16'h55FF, "unmapped_wr_ignored");
        step(0, 0, 3'd0, 2'b00, 16'h0000);
        expect_at(cyc, C0_A, 16'h55FF, "be0_wr_ignored");
        expect_at(cyc, RD_A, 16'h0000, "rdata_zero_no_en");

        // Registered read and status shadowing (dut_s)
        idle();
        stat_en = 1'b1;
        idle();
        stat_en = 1'b0;
        step(1, 0, 3'd4, 2'b00, 16'h0000);
        expect_at(cyc, RD_A, 16'h0002, "async_rd_stat2");
        expect_at(cyc + 1, RD_S, 16'h0002, "sync_rd_stat2");
        idle();
        expect_at(cyc + 1, RD_S, 16'h0002, "sync_rd_hold");
        idle();
        stat_s[2] = 16'h00AA;
        step(1, 0, 3'd4, 2'b00, 16'h0000);
        expect_at(cyc + 1, RD_S, 16'h0002, "shadow_hold");
        idle();
        stat_en = 1'b1;
        idle();
        stat_en = 1'b0;
        step(1, 0, 3'd4, 2'b00, 16'h0000);
        expect_at(cyc + 1, RD_S, 16'h00AA, "shadow_capture");
        step(1, 0, 3'd0, 2'b00, 16'h0000);
        expect_at(cyc + 1, RD_S, 16'h55FF, "sync_rd_ctrl0");
        idle();

        // Reset between two writes
        step(1, 1, 3'd0, 2'b11, 16'h1234);
        idle();
        expect_at(cyc, C0_A, 16'h1234, "pre_reset_ctrl0");
        @(posedge clk_s);
        #1;
        rst_n_s = 1'b0;
        expect_at(cyc, C0_A, 16'h0000, "midrst_ctrl0");
        expect_at(cyc, C1_A, 16'h0000, "midrst_ctrl1");
        expect_at(cyc, C0_S, 16'h0000, "midrst_ctrl0_s");
        expect_at(cyc, RD_S, 16'h0000, "midrst_rdata_s");
        step(1, 1, 3'd1, 2'b11, 16'h5678);
        rst_n_s = 1'b1;
        expect_at(cyc + 1, C1_A, 16'h5678, "post_reset_wr");
        expect_at(cyc + 1, C0_A, 16'h0000, "post_reset_ctrl0");
        idle();

        repeat (3) @(posedge clk_s);
        #1;
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain left=%0d", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
